// File: rtl/div_pkg.sv
// Shared types and constants for the divide issue/retire controller.
// Op encoding matches the funct3[1:0] ordering used by execute.
package div_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'd0,
      DIVU = 2'd1,
      REM  = 2'd2,
      REMU = 2'd3
   } div_op_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      DRAIN = 3'd4
   } div_state_e;

   localparam logic [31:0] ONES32 = 32'hFFFF_FFFF;
   localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [31:0] MIN32  = 32'h8000_0000;
   localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;

   function automatic logic [63:0] sext_w(input logic [63:0] r);
      return {{32{r[31]}}, r[31:0]};
   endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response bus between execute, the divide controller and writeback.
// master = execute/writeback side, slave = controller.
interface div_ctrl_if #(parameter int TAG_W = 5);

   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic             in_word;
   logic [63:0]      in_a;
   logic [63:0]      in_b;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [63:0]      out_result;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_op, in_word, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag
   );

   modport slave (
      input  in_valid, in_op, in_word, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag
   );

endinterface

// File: rtl/div_ctrl_chk.sv
// Protocol assertions for div_ctrl: divider handshake sanity and result hold.
module div_ctrl_chk (
   input logic        clk,
   input logic        rst_n,
   input logic        flush,
   input logic        done_expected,
   input logic        div_done,
   input logic        div_start,
   input logic        out_valid,
   input logic        out_ready,
   input logic [63:0] out_result
);

   a_done_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
      div_done |-> done_expected);

   a_start_single: assert property (@(posedge clk) disable iff (!rst_n)
      div_start |=> !div_start);

   a_result_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_result)));

endmodule

// File: rtl/div_special.sv
// Divide-by-zero and signed-overflow resolution, evaluated on the effective
// operands; the result is already sign-extended for W ops.
module div_special
   import div_pkg::*;
(
   input  logic [1:0]  op,
   input  logic        word,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic        is_special,
   output logic [63:0] special_result
);

   logic        sgn;
   logic        want_rem;
   logic        zero;
   logic        ovf;
   logic [63:0] a_eff;

   // Classify the operands and form the architectural result for special cases
   always_comb begin
      sgn      = (op == DIV) || (op == REM);
      want_rem = (op == REM) || (op == REMU);
      a_eff    = word ? sext_w(a) : a;
      if (word) begin
         zero = (b[31:0] == 32'd0);
         ovf  = sgn && (a[31:0] == MIN32) && (b[31:0] == ONES32);
      end else begin
         zero = (b == 64'd0);
         ovf  = sgn && (a == MIN64) && (b == ONES64);
      end
      is_special = zero || ovf;
      if (zero) begin
         special_result = want_rem ? a_eff : ONES64;
      end else if (ovf) begin
         special_result = want_rem ? 64'd0 : a_eff;
      end else begin
         special_result = 64'd0;
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// Issue/retire controller in front of the radix-2 divider: resolves special
// cases locally, otherwise launches the divider and holds its result for writeback.
module div_ctrl
   import div_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   div_ctrl_if.slave   bus,
   output logic        div_start,
   output logic        div_sign,
   output logic        div_word,
   output logic [63:0] div_dividend,
   output logic [63:0] div_divisor,
   input  logic [63:0] div_quotient,
   input  logic [63:0] div_remainder,
   input  logic        div_done
);

   div_state_e  state;
   logic [1:0]  op;
   logic        accept;
   logic        is_special;
   logic [63:0] special_result;
   logic [63:0] div_pick;
   logic [63:0] div_fmt;

   assign bus.in_ready = (state == IDLE) && !flush;
   assign accept       = bus.in_valid && bus.in_ready;

   div_special u_special (
      .op             (bus.in_op),
      .word           (bus.in_word),
      .a              (bus.in_a),
      .b              (bus.in_b),
      .is_special     (is_special),
      .special_result (special_result)
   );

   // Select quotient or remainder and sign-extend W results
   always_comb begin
      div_pick = div_quotient;
      if ((op == REM) || (op == REMU)) begin
         div_pick = div_remainder;
      end else begin
         div_pick = div_quotient;
      end
      div_fmt = div_word ? sext_w(div_pick) : div_pick;
   end

   // Control FSM plus operand and result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         op             <= 2'd0;
         div_start      <= 1'b0;
         div_sign       <= 1'b0;
         div_word       <= 1'b0;
         div_dividend   <= 64'd0;
         div_divisor    <= 64'd0;
         bus.out_valid  <= 1'b0;
         bus.out_result <= 64'd0;
         bus.out_tag    <= {TAG_W{1'b0}};
      end else begin
         div_start <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  op           <= bus.in_op;
                  div_sign     <= (bus.in_op == DIV) || (bus.in_op == REM);
                  div_word     <= bus.in_word;
                  div_dividend <= bus.in_a;
                  div_divisor  <= bus.in_b;
                  bus.out_tag  <= bus.in_tag;
                  if (is_special) begin
                     bus.out_result <= special_result;
                     bus.out_valid  <= 1'b1;
                     state          <= RESP;
                  end else begin
                     div_start <= 1'b1;
                     state     <= ISSUE;
                  end
               end
            end
            // The divider cannot abort, so a flushed launch must be drained
            ISSUE: begin
               state <= flush ? DRAIN : WAIT;
            end
            WAIT: begin
               if (flush) begin
                  state <= div_done ? IDLE : DRAIN;
               end else if (div_done) begin
                  bus.out_result <= div_fmt;
                  bus.out_valid  <= 1'b1;
                  state          <= RESP;
               end
            end
            RESP: begin
               if (flush || bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            DRAIN: begin
               if (div_done) begin
                  state <= IDLE;
               end
            end
            default: begin
               bus.out_valid <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

   div_ctrl_chk u_chk (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .done_expected ((state == WAIT) || (state == DRAIN)),
      .div_done      (div_done),
      .div_start     (div_start),
      .out_valid     (bus.out_valid),
      .out_ready     (bus.out_ready),
      .out_result    (bus.out_result)
   );

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed cases plus randomized ops against an
// arithmetic reference model, with a fixed-latency divider model.
module tb_div_ctrl;
   import div_pkg::*;

   localparam int TAG_W   = 5;
   localparam int DIV_LAT = 65;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        div_start, div_sign, div_word, div_done;
   logic [63:0] div_dividend, div_divisor, div_quotient, div_remainder;

   div_ctrl_if #(.TAG_W(TAG_W)) bus ();

   div_ctrl #(.TAG_W(TAG_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .bus           (bus),
      .div_start     (div_start),
      .div_sign      (div_sign),
      .div_word      (div_word),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder),
      .div_done      (div_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0]      res;
      logic [TAG_W-1:0] tag;
      int               acc;
      int               lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   exp_starts = 0;
   int   got_starts = 0;
   int   last_acc = -100;
   int   rdy_mode = 2;

   task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic checkint(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // RISC-V M-extension semantics from plain arithmetic
   function automatic void ref_model(input logic [1:0] op, input logic word,
                                     input logic [63:0] a, input logic [63:0] b,
                                     output logic [63:0] res, output bit special);
      bit                 sgn;
      logic signed [63:0] sa, sb_v;
      logic [63:0]        ua, ub, q, r;
      sgn = (op == 2'd0) || (op == 2'd2);
      if (word) begin
         ua   = {32'd0, a[31:0]};
         ub   = {32'd0, b[31:0]};
         sa   = $signed({{32{a[31]}}, a[31:0]});
         sb_v = $signed({{32{b[31]}}, b[31:0]});
      end else begin
         ua   = a;
         ub   = b;
         sa   = $signed(a);
         sb_v = $signed(b);
      end
      special = 1'b0;
      if (ub == 64'd0) begin
         q = 64'hFFFF_FFFF_FFFF_FFFF;
         r = a;
         special = 1'b1;
      end else if (sgn && sb_v == -64'sd1 &&
                   sa == $signed(word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
         q = a;
         r = 64'd0;
         special = 1'b1;
      end else if (sgn) begin
         q = sa / sb_v;
         r = sa % sb_v;
      end else begin
         q = ua / ub;
         r = ua % ub;
      end
      res = op[1] ? r : q;
      if (word) res = {{32{res[31]}}, res[31:0]};
   endfunction

   // Divider behaviour: W results carry junk in the upper half
   task automatic div_compute(input logic sgn, input logic word, input logic [63:0] a,
                              input logic [63:0] b, output logic [63:0] q, output logic [63:0] r);
      logic [63:0] ea, eb;
      ea = word ? (sgn ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
      eb = word ? (sgn ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
      if (eb == 64'd0) begin
         q = 64'hFFFF_FFFF_FFFF_FFFF;
         r = ea;
      end else if (sgn && ea == 64'h8000_0000_0000_0000 && eb == 64'hFFFF_FFFF_FFFF_FFFF) begin
         q = ea;
         r = 64'd0;
      end else if (sgn) begin
         q = $signed(ea) / $signed(eb);
         r = $signed(ea) % $signed(eb);
      end else begin
         q = ea / eb;
         r = ea % eb;
      end
      if (word) begin
         q = {$urandom, q[31:0]};
         r = {$urandom, r[31:0]};
      end
   endtask

   int          dcnt = 0;
   logic [63:0] dq, dr;
   initial begin
      div_done = 1'b0;
      div_quotient = 64'd0;
      div_remainder = 64'd0;
      forever begin
         @(negedge clk);
         if (rst_n && div_start) begin
            got_starts++;
            checkint("start_cycle", cyc, last_acc + 1);
            checkint("start_while_busy", dcnt, 0);
            div_compute(div_sign, div_word, div_dividend, div_divisor, dq, dr);
            dcnt = DIV_LAT;
         end
         @(posedge clk);
         #1;
         div_done = 1'b0;
         if (!rst_n) begin
            dcnt = 0;
         end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
               div_done = 1'b1;
               div_quotient = dq;
               div_remainder = dr;
            end
         end
      end
   end

   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: bus.out_ready = 1'($urandom_range(0, 1));
            1: bus.out_ready = 1'b0;
            default: bus.out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: compare every presented result against the scoreboard head
   logic [63:0]      hold_res;
   logic [TAG_W-1:0] hold_tag;
   bit               presented = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && !flush && bus.out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: out_valid with nothing pending, result %h", bus.out_result);
            end else begin
               if (!presented) begin
                  checkint("latency", cyc - sb[0].acc, sb[0].lat);
                  check64("result", bus.out_result, sb[0].res);
                  checkint("tag", bus.out_tag, sb[0].tag);
                  hold_res = bus.out_result;
                  hold_tag = bus.out_tag;
                  presented = 1'b1;
               end else begin
                  check64("hold_result", bus.out_result, hold_res);
                  checkint("hold_tag", bus.out_tag, hold_tag);
               end
               if (bus.out_ready) begin
                  void'(sb.pop_front());
                  presented = 1'b0;
               end
            end
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input int flush_at);
      logic [63:0]      res;
      bit               sp;
      int               t;
      int               waited;
      exp_t             e;
      logic [TAG_W-1:0] tag;
      tag = TAG_W'($urandom);
      ref_model(op, word, a, b, res, sp);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_op = op;
      bus.in_word = word;
      bus.in_a = a;
      bus.in_b = b;
      bus.in_tag = tag;
      waited = 0;
      @(negedge clk);
      while (!bus.in_ready) begin
         waited++;
         if (waited > 300) begin
            checkint("accept_timeout", waited, 0);
            bus.in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      t = cyc;
      last_acc = t;
      if (!sp) exp_starts++;
      if (flush_at < 0) begin
         e.res = res;
         e.tag = tag;
         e.acc = t;
         e.lat = sp ? 1 : 67;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (flush_at > 0) begin
         repeat (flush_at - 1) begin
            @(posedge clk);
            #1;
         end
         flush = 1'b1;
         @(posedge clk);
         #1;
         flush = 1'b0;
         waited = 0;
         @(negedge clk);
         while (!bus.in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
         end
         checkint("flush_ready_cycle", cyc - t, sp ? 2 : 67);
      end
   endtask

   task automatic wait_idle();
      int waited = 0;
      @(negedge clk);
      while ((sb.size() != 0 || !bus.in_ready) && waited < 500) begin
         waited++;
         @(negedge clk);
      end
      checkint("drain_timeout", waited < 500 ? 0 : 1, 0);
   endtask

   function automatic logic [63:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 64'd0;
         1: return 64'hFFFF_FFFF_FFFF_FFFF;
         2: return 64'h8000_0000_0000_0000;
         3: return {32'($urandom), 32'h8000_0000};
         4: return 64'($urandom_range(0, 100));
         default: return {32'($urandom), 32'($urandom)};
      endcase
   endfunction

   initial begin
      int          waited;
      logic [63:0] ra, rb;
      logic [1:0]  rop;
      logic        rw;
      logic [63:0] rres;
      bit          rsp;
      int          fa;
      bus.in_valid = 1'b0;
      bus.in_op = 2'd0;
      bus.in_word = 1'b0;
      bus.in_a = 64'd0;
      bus.in_b = 64'd0;
      bus.in_tag = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkint("rst_out_valid", bus.out_valid, 0);
      check64("rst_out_result", bus.out_result, 64'd0);
      checkint("rst_out_tag", bus.out_tag, 0);
      checkint("rst_div_start", div_start, 0);
      check64("rst_dividend", div_dividend, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkint("idle_in_ready", bus.in_ready, 1);

      issue(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, -1);
      issue(REMU, 1'b0, 64'h8000_0000_0000_0005, 64'd0, -1);
      issue(DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, -1);
      issue(REM, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, -1);
      issue(DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, -1);
      issue(DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, -1);
      issue(REMU, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, -1);
      wait_idle();

      // Backpressure, then a back-to-back second op
      rdy_mode = 1;
      issue(DIVU, 1'b0, 64'd1000, 64'd3, -1);
      waited = 0;
      @(negedge clk);
      while (!bus.out_valid && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      repeat (10) begin
         checkint("bp_in_ready", bus.in_ready, 0);
         checkint("bp_out_valid", bus.out_valid, 1);
         @(negedge clk);
      end
      rdy_mode = 2;
      issue(REM, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, -1);
      wait_idle();

      // Flushes: ISSUE, coincident with done, WAIT, RESP, and IDLE
      issue(DIV, 1'b0, 64'd5000, 64'd13, 1);
      issue(DIVU, 1'b0, 64'd5000, 64'd13, 66);
      issue(REM, 1'b1, 64'd77, 64'd5, 30);
      issue(DIVU, 1'b0, 64'd9, 64'd0, 1);
      issue(DIVU, 1'b0, 64'd100, 64'd7, -1);
      wait_idle();
      @(posedge clk);
      #1;
      flush = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_op = 2'd1;
      bus.in_b = 64'd0;
      @(negedge clk);
      checkint("idle_flush_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);

      // Randomized ops with random backpressure and occasional flushes
      rdy_mode = 0;
      for (int i = 0; i < 40; i++) begin
         ra = rand_operand();
         rb = rand_operand();
         rop = 2'($urandom_range(0, 3));
         rw = 1'($urandom_range(0, 1));
         ref_model(rop, rw, ra, rb, rres, rsp);
         fa = -1;
         if ($urandom_range(0, 7) == 0) fa = rsp ? 1 : int'($urandom_range(1, 66));
         issue(rop, rw, ra, rb, fa);
      end
      rdy_mode = 2;
      wait_idle();
      checkint("start_count", got_starts, exp_starts);
      checkint("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Issue/retire controller directly upstream of the 64-iteration radix-2 divider (`div`) in the ALU.
- Accepts RISC-V M-extension divide ops (DIV/DIVU/REM/REMU and their W forms) from execute via valid/ready.
- Resolves divide-by-zero and signed overflow locally, without using the divider.
- Otherwise launches the divider, waits for its done pulse, selects quotient or remainder, sign-extends W results, and holds the result until the writeback side accepts it.

Parameters:
TAG_W, 5, width of the opaque tag (rd index / ROB id) carried from input to output.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
flush  in  1  kill the in-flight op; its result is never presented
in_valid  in  1  op request
in_ready  out  1  controller can accept an op this cycle
in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
in_word  in  1  W variant (32-bit operands, sign-extended 32-bit result)
in_a  in  64  dividend (rs1)
in_b  in  64  divisor (rs2)
in_tag  in  TAG_W  op tag
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  64  final rd value
out_tag  out  TAG_W  tag of the result
div_start  out  1  one-cycle launch pulse to divider div_valid
div_sign  out  1  signed op (DIV/REM)
div_word  out  1  to divider divw
div_dividend  out  64  registered in_a
div_divisor  out  64  registered in_b
div_quotient  in  64  divider quotient
div_remainder  in  64  divider remainder
div_done  in  1  divider out_valid, single-cycle pulse

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- Reset: state=IDLE; out_valid=0; div_start=0; out_result=0; out_tag=0; operand registers=0.
  - The divider shares rst_n, so a reset mid-operation leaves both blocks idle and no result ever emerges.
- in_ready = (state==IDLE) & ~flush. One op in flight; no overlap.
- Accept (in_valid & in_ready, cycle T): latch op, word, a, b, tag. Evaluate special cases on the effective operands (low 32 bits when in_word, signed or unsigned per op):
  - Divisor zero: quotient = all ones; remainder = dividend. Go to RESP, out_valid at T+1.
  - Signed overflow (dividend = most-negative value for the width, divisor = -1): quotient = dividend; remainder = 0. Go to RESP, out_valid at T+1.
  - Otherwise: go to ISSUE.
- ISSUE: div_start=1 for exactly this one cycle. div_dividend, div_divisor, div_sign and div_word are stable from ISSUE until div_done. Go to WAIT.
- WAIT: on div_done, capture the quotient (DIV/DIVU) or remainder (REM/REMU), then go to RESP.
  - With the team divider, out_valid asserts at T+67.
- W results:
  - Special-case results are formed on 32-bit values.
  - out_result = {32{r[31]}, r[31:0]} for all W ops, including DIVUW/REMUW.
- RESP:
  - out_valid=1; out_result and out_tag hold stable while out_ready=0.
  - On out_ready, go to IDLE with out_valid=0 next cycle; the next op is accepted no earlier than the following cycle.
- flush:
  - In IDLE: no effect; any in_valid that cycle is not accepted.
  - In ISSUE: div_start still pulses (the divider cannot abort); go to DRAIN.
  - In WAIT: go to DRAIN. If div_done arrives in the same cycle, discard it and go to IDLE.
  - In RESP: drop the result and go to IDLE; out_valid=0 next cycle even if out_ready was high.
- DRAIN: in_ready=0, out_valid=0. On div_done, discard the result and go to IDLE. flush has no further effect.
- div_done outside WAIT/DRAIN: ignored (defensive check; flag it in assertions).

Decomposition:
- Package div_pkg holds:
  - enum div_op_e {DIV, DIVU, REM, REMU}
  - enum div_state_e
  - constants for the all-ones and most-negative values at 32 and 64 bits
- One sub-module, div_special: combinational. Takes op, word, a, b; returns is_special and special_result, already W-sign-extended. This lets the special-case table be unit-tested alone.

Test Plan:
- DIV a=-7, b=2, word=0 -> div_start at T+1; out_result=-3 (0xFFFF_FFFF_FFFF_FFFD) at T+67 with the same tag.
- REMU a=0x8000_0000_0000_0005, b=0 -> no div_start; out_result=0x8000_0000_0000_0005 at T+1.
- DIVW a=0x0000_0000_8000_0000, b=0xFFFF_FFFF_FFFF_FFFF -> overflow; out_result=0xFFFF_FFFF_8000_0000 at T+1. Same with REMW -> 0.
- DIVUW a=0xFFFF_FFFF, b=1 -> divider path; out_result=0xFFFF_FFFF_FFFF_FFFF (bit 31 sign-extension).
- Backpressure: out_ready=0 for 10 cycles after out_valid -> result and tag stable, in_ready=0. out_ready=1 -> IDLE; back-to-back second op returns the correct result.
- flush in the cycle after acceptance (ISSUE), plus flush coinciding with div_done -> no out_valid. in_ready returns only after div_done; a following DIVU 100/7 yields 14.
